fir_mdc_job_dispatcher: RTL and testbench
=========================================

Name: fir_mdc_job_dispatcher

Overview:
Hardware initiator for the FIR MDC accelerator's peripheral configuration port. It takes a job descriptor (parameter words) over a valid/ready handshake and acquires a job context. It writes the parameters into the job register window, triggers execution, waits for the completion event, then reports done with the job ID. It sits on the master side of hwpe_ctrl_intf_periph, replacing core-driven programming in DMA-less or autonomous test configurations.

Parameters:
N_PARAMS, 24, number of 32-bit job parameter words written per job (window offsets 0x40 + 4*i)
BASE_ADDR, 32'h0000_0000, base address of the accelerator register space
ID, 10, periph transaction ID width
BACKOFF_CYCLES, 16, idle cycles between failed acquire attempts
EVT_IDX, 0, index into evt_i of the completion event line

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous soft clear; aborts to IDLE
job_valid_i  input  1  descriptor valid
job_ready_o  output  1  descriptor accepted (high only in IDLE)
job_params_i  input  N_PARAMS*32  parameter words, sampled on valid&ready
done_o  output  1  one-cycle pulse on job completion
done_job_id_o  output  8  job ID returned by acquire
busy_o  output  1  high in every state except IDLE
evt_i  input  REGFILE_N_EVT  accelerator event lines for this initiator's core slot
periph  master  hwpe_ctrl_intf_periph  req/gnt/add/wen/be/data/id/r_data/r_valid/r_id

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active-low. One clock domain only.
- Reset/clear values: state IDLE; periph.req=0, add=0, wen=1, be=0, data=0, id=0; done_o=0; done_job_id_o=0; busy_o=0; internal param buffer and counters 0.
- FSM: IDLE -> ACQ -> ACQ_RSP -> (BACKOFF -> ACQ) | WR -> WR_RSP -> (WR | TRIG) -> TRIG_RSP -> WAIT_EVT -> DONE -> IDLE.
- IDLE: job_ready_o=1. On job_valid_i, latch job_params_i, go to ACQ.
- Request rule: req asserted with stable add/wen/be/data/id until the cycle gnt=1. Only one transaction is outstanding at a time. The next req is raised only after r_valid for the previous one. Back-to-back req is not required.
- ACQ: read (wen=1) of BASE_ADDR+0x04.
- ACQ_RSP: on r_valid, r_data==32'hFFFF_FFFF means no free context. The block then goes to BACKOFF and counts BACKOFF_CYCLES cycles, then retries. Otherwise r_data[7:0] is latched as the job ID. The param index is reset to 0 and the FSM goes to WR.
- WR: write (wen=0, be=4'hF) of param[idx] to BASE_ADDR+0x40+4*idx. WR_RSP increments idx on r_valid. When idx reaches N_PARAMS-1, the next state is TRIG instead of WR.
- TRIG: write 32'h0 to BASE_ADDR+0x00.
- WAIT_EVT: wait for evt_i[EVT_IDX]==1. An event already high in the cycle TRIG_RSP completes counts; it is not lost.
- DONE: done_o=1 for exactly one cycle with done_job_id_o valid. done_job_id_o holds its value until the next acquire succeeds.
- periph.id is a constant 0. An r_valid with r_id!=0 is ignored; the FSM keeps waiting.
- r_valid arriving in a state with no outstanding transaction is ignored.
- clear_i takes precedence over every transition. It drops req in the same cycle and returns to IDLE, even with a granted transaction pending. Its response is discarded.
- Latency for N_PARAMS=24, gnt and r_valid each one cycle after req, acquire succeeding first time: 2*(1+24+1) cycles of bus traffic plus event wait plus 1 DONE cycle.

Decomposition:
- Shared package (fir_mdc_package): register offsets (trigger 0x00, acquire 0x04, status 0x0C, job window base 0x40), the acquire-fail constant 32'hFFFF_FFFF and a dispatcher state enum.
- One natural sub-module: fir_mdc_periph_master_port. It owns the req/gnt/r_valid single-outstanding handshake and presents a simple cmd_valid/cmd_ready/rsp_valid interface to the FSM.

Test Plan:
- Nominal: N_PARAMS=4, params {1,2,3,4}; slave grants immediately, acquire returns 0x00000003. Required: writes to 0x40..0x4C with 1..4, then a write to 0x00; evt pulse -> done_o one cycle, done_job_id_o=3.
- Acquire busy: acquire returns 0xFFFFFFFF twice then 0x1. Required: exactly 16 idle cycles between reads; three acquire reads total; job ID 1.
- Grant stall: gnt held low 5 cycles on the third write. Required: req, add and data stable for all 6 cycles; no extra write issued.
- Event coincident: evt_i high in the same cycle as the trigger response. Required: done_o pulses without waiting for a further event.
- Clear mid-write: clear_i asserted while req is high in WR. Required: req=0 the next cycle, busy_o=0, job_ready_o=1; a late r_valid is ignored and a new job runs cleanly.
- Async reset mid-job: rst_ni low in WAIT_EVT. Required: all outputs take their reset values immediately; done_o is never pulsed.

Source files
------------

// File: rtl/fir_mdc_job_dispatcher_pkg.sv
// Shared constants and types for the FIR MDC job dispatcher:
// register offsets, the acquire-fail marker and the dispatcher state encoding.
package fir_mdc_package;

    localparam int unsigned REGFILE_N_EVT = 4;

    localparam logic [31:0] OFS_TRIGGER  = 32'h0000_0000;
    localparam logic [31:0] OFS_ACQUIRE  = 32'h0000_0004;
    localparam logic [31:0] OFS_STATUS   = 32'h0000_000C;
    localparam logic [31:0] OFS_JOB_WIN  = 32'h0000_0040;

    // Value returned by an acquire read when no job context is free
    localparam logic [31:0] ACQUIRE_FAIL = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        DS_IDLE,
        DS_ACQ,
        DS_ACQ_RSP,
        DS_BACKOFF,
        DS_WR,
        DS_WR_RSP,
        DS_TRIG,
        DS_TRIG_RSP,
        DS_WAIT_EVT,
        DS_DONE
    } disp_state_e;

    // Address of job parameter word idx inside the job register window
    function automatic logic [31:0] job_win_addr(input logic [31:0] base, input int unsigned idx);
        return base + OFS_JOB_WIN + (32'(idx) << 2);
    endfunction

endpackage

// File: rtl/fir_mdc_periph_master_port.sv
// Single-outstanding master port on the periph bus. The FSM holds a command
// steady until it is granted; the port tracks the one granted transaction and
// forwards only its response (r_id 0). abort_i drops req combinationally and
// forgets any pending response.
module fir_mdc_periph_master_port #(
    parameter int unsigned ID = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          abort_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [31:0]   cmd_add_i,
    input  logic          cmd_wen_i,
    input  logic [31:0]   cmd_data_i,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_data_o,
    output logic          periph_req_o,
    input  logic          periph_gnt_i,
    output logic [31:0]   periph_add_o,
    output logic          periph_wen_o,
    output logic [3:0]    periph_be_o,
    output logic [31:0]   periph_data_o,
    output logic [ID-1:0] periph_id_o,
    input  logic [31:0]   periph_r_data_i,
    input  logic          periph_r_valid_i,
    input  logic [ID-1:0] periph_r_id_i
);

    logic pend_q, pend_d;

    // No new request while a granted transaction still awaits its response
    assign periph_req_o  = cmd_valid_i & ~pend_q & ~abort_i;
    assign periph_add_o  = periph_req_o ? cmd_add_i  : 32'h0;
    assign periph_wen_o  = periph_req_o ? cmd_wen_i  : 1'b1;
    assign periph_be_o   = periph_req_o ? 4'hF       : 4'h0;
    assign periph_data_o = periph_req_o ? cmd_data_i : 32'h0;
    assign periph_id_o   = '0;

    assign cmd_ready_o   = periph_req_o & periph_gnt_i;
    assign rsp_valid_o   = pend_q & periph_r_valid_i & (periph_r_id_i == '0) & ~abort_i;
    assign rsp_data_o    = periph_r_data_i;

    // Outstanding-transaction flag: set on grant, cleared on its response or abort
    always_comb begin
        pend_d = pend_q;
        if (abort_i)          pend_d = 1'b0;
        else if (cmd_ready_o) pend_d = 1'b1;
        else if (rsp_valid_o) pend_d = 1'b0;
    end

    // Pending flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= 1'b0;
        else         pend_q <= pend_d;
    end

endmodule

// File: rtl/fir_mdc_job_dispatcher.sv
// Autonomous job initiator: acquires a context, writes the job parameters
// into the register window, triggers, waits for the completion event and
// reports done with the acquired job ID.
module fir_mdc_job_dispatcher
    import fir_mdc_package::*;
#(
    parameter int unsigned N_PARAMS       = 24,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned ID             = 10,
    parameter int unsigned BACKOFF_CYCLES = 16,
    parameter int unsigned EVT_IDX        = 0,
    parameter int unsigned N_EVT          = REGFILE_N_EVT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [N_PARAMS*32-1:0] job_params_i,
    output logic                  done_o,
    output logic [7:0]            done_job_id_o,
    output logic                  busy_o,
    input  logic [N_EVT-1:0]      evt_i,
    output logic                  periph_req_o,
    input  logic                  periph_gnt_i,
    output logic [31:0]           periph_add_o,
    output logic                  periph_wen_o,
    output logic [3:0]            periph_be_o,
    output logic [31:0]           periph_data_o,
    output logic [ID-1:0]         periph_id_o,
    input  logic [31:0]           periph_r_data_i,
    input  logic                  periph_r_valid_i,
    input  logic [ID-1:0]         periph_r_id_i
);

    localparam int unsigned IDX_W = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;
    localparam int unsigned BO_W  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES + 1) : 1;

    disp_state_e                 state_q, state_d;
    logic [N_PARAMS-1:0][31:0]   params_q, params_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [BO_W-1:0]             bo_q, bo_d;
    logic [7:0]                  job_id_q, job_id_d;
    logic                        evt_seen_q, evt_seen_d;

    logic        cmd_valid, cmd_ready, cmd_wen, rsp_valid, evt;
    logic [31:0] cmd_add, cmd_data, rsp_data;
    logic        unused_evt;

    assign evt        = evt_i[EVT_IDX];
    assign unused_evt = ^evt_i;

    assign job_ready_o   = (state_q == DS_IDLE);
    assign busy_o        = (state_q != DS_IDLE);
    assign done_o        = (state_q == DS_DONE);
    assign done_job_id_o = job_id_q;

    fir_mdc_periph_master_port #(.ID(ID)) u_port (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .abort_i          (clear_i),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_add_i        (cmd_add),
        .cmd_wen_i        (cmd_wen),
        .cmd_data_i       (cmd_data),
        .rsp_valid_o      (rsp_valid),
        .rsp_data_o       (rsp_data),
        .periph_req_o     (periph_req_o),
        .periph_gnt_i     (periph_gnt_i),
        .periph_add_o     (periph_add_o),
        .periph_wen_o     (periph_wen_o),
        .periph_be_o      (periph_be_o),
        .periph_data_o    (periph_data_o),
        .periph_id_o      (periph_id_o),
        .periph_r_data_i  (periph_r_data_i),
        .periph_r_valid_i (periph_r_valid_i),
        .periph_r_id_i    (periph_r_id_i)
    );

    // Dispatcher sequencing and bus command generation; clear overrides everything
    always_comb begin
        state_d    = state_q;
        params_d   = params_q;
        idx_d      = idx_q;
        bo_d       = bo_q;
        job_id_d   = job_id_q;
        evt_seen_d = evt_seen_q;
        cmd_valid  = 1'b0;
        cmd_add    = 32'h0;
        cmd_wen    = 1'b1;
        cmd_data   = 32'h0;
        unique case (state_q)
            DS_IDLE: if (job_valid_i) begin
                params_d = job_params_i;
                state_d  = DS_ACQ;
            end
            DS_ACQ: begin
                cmd_valid = 1'b1;
                cmd_add   = BASE_ADDR + OFS_ACQUIRE;
                if (cmd_ready) state_d = DS_ACQ_RSP;
            end
            DS_ACQ_RSP: if (rsp_valid) begin
                if (rsp_data == ACQUIRE_FAIL) begin
                    bo_d    = '0;
                    state_d = DS_BACKOFF;
                end else begin
                    job_id_d = rsp_data[7:0];
                    idx_d    = '0;
                    state_d  = DS_WR;
                end
            end
            DS_BACKOFF: begin
                bo_d = bo_q + 1'b1;
                if (32'(bo_q) == BACKOFF_CYCLES - 1) state_d = DS_ACQ;
            end
            DS_WR: begin
                cmd_valid = 1'b1;
                cmd_wen   = 1'b0;
                cmd_add   = job_win_addr(BASE_ADDR, 32'(idx_q));
                cmd_data  = params_q[idx_q];
                if (cmd_ready) state_d = DS_WR_RSP;
            end
            DS_WR_RSP: if (rsp_valid) begin
                if (32'(idx_q) == N_PARAMS - 1) begin
                    state_d = DS_TRIG;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DS_WR;
                end
            end
            DS_TRIG: begin
                cmd_valid  = 1'b1;
                cmd_wen    = 1'b0;
                cmd_add    = BASE_ADDR + OFS_TRIGGER;
                evt_seen_d = 1'b0;
                if (cmd_ready) state_d = DS_TRIG_RSP;
            end
            // An event coinciding with the trigger response is remembered
            DS_TRIG_RSP: if (rsp_valid) begin
                evt_seen_d = evt;
                state_d    = DS_WAIT_EVT;
            end
            DS_WAIT_EVT: if (evt || evt_seen_q) begin
                evt_seen_d = 1'b0;
                state_d    = DS_DONE;
            end
            DS_DONE: state_d = DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
        if (clear_i) begin
            state_d    = DS_IDLE;
            params_d   = '0;
            idx_d      = '0;
            bo_d       = '0;
            job_id_d   = '0;
            evt_seen_d = 1'b0;
        end
    end

    // State, parameter buffer and counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= DS_IDLE;
            params_q   <= '0;
            idx_q      <= '0;
            bo_q       <= '0;
            job_id_q   <= '0;
            evt_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            params_q   <= params_d;
            idx_q      <= idx_d;
            bo_q       <= bo_d;
            job_id_q   <= job_id_d;
            evt_seen_q <= evt_seen_d;
        end
    end

endmodule

// File: tb/tb_fir_mdc_job_dispatcher.sv
// Bench for fir_mdc_job_dispatcher: a periph slave model logs every granted
// transaction; each job is checked against a transaction list derived from
// the job descriptor and the scripted acquire responses.
module tb_fir_mdc_job_dispatcher;
    import fir_mdc_package::*;

    localparam int NP  = 4;
    localparam int BO  = 16;
    localparam int IDW = 10;
    localparam int NE  = 4;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, job_valid = 1'b0;
    logic [NP*32-1:0] job_params = '0;
    logic job_ready, done, busy, req, wen;
    logic [7:0] done_id;
    logic [31:0] add, data;
    logic [3:0] be;
    logic [IDW-1:0] id;
    logic gnt = 1'b0, r_valid = 1'b0;
    logic [31:0] r_data = '0;
    logic [IDW-1:0] r_id = '0;
    logic [NE-1:0] evt = '0;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fir_mdc_job_dispatcher #(.N_PARAMS(NP), .BASE_ADDR(32'h0), .ID(IDW),
        .BACKOFF_CYCLES(BO), .EVT_IDX(0), .N_EVT(NE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .job_valid_i(job_valid),
        .job_ready_o(job_ready), .job_params_i(job_params), .done_o(done),
        .done_job_id_o(done_id), .busy_o(busy), .evt_i(evt),
        .periph_req_o(req), .periph_gnt_i(gnt), .periph_add_o(add), .periph_wen_o(wen),
        .periph_be_o(be), .periph_data_o(data), .periph_id_o(id),
        .periph_r_data_i(r_data), .periph_r_valid_i(r_valid), .periph_r_id_i(r_id));

    // configuration written by the stimulus block only
    logic [31:0] acq_tab [0:63];
    int stall_at = -1, stall_len = 0, evt_delay = 0, bad_rid_req = 0;
    logic inject_rv = 1'b0;

    // slave state
    int cyc = 0, acq_ptr = 0, wr_ord = 0, stall_left = 0, stall_req_cyc = 0;
    int evt_cnt = 0, trig_rsp_cnt = 0, bad_rid_done = 0;
    bit stalling = 0, stall_unstable = 0, rsp_due = 0, rsp_trig = 0;
    logic [31:0] snap_add, snap_data, rsp_val;
    logic [31:0] log_add[$], log_data[$];
    logic        log_wen[$];
    logic [3:0]  log_be[$];
    int          acq_cyc[$];

    // periph slave: grants (optionally stalled), responds one cycle after grant
    always @(negedge clk) begin
        cyc++;
        gnt = 1'b0; r_valid = 1'b0; r_id = '0; evt = '0;
        if (!rst_n || clear) begin
            rsp_due = 0; stalling = 0; evt_cnt = 0;
        end else begin
            if (evt_cnt > 0) begin
                evt_cnt--;
                if (evt_cnt == 0) evt[0] = 1'b1;
            end
            if (rsp_due) begin
                if (bad_rid_done < bad_rid_req) begin
                    r_valid = 1'b1; r_id = 1; r_data = ACQUIRE_FAIL; bad_rid_done++;
                end else begin
                    r_valid = 1'b1; r_data = rsp_val; rsp_due = 0;
                    if (rsp_trig) begin
                        trig_rsp_cnt++;
                        if (evt_delay == 0) evt[0] = 1'b1; else evt_cnt = evt_delay;
                    end
                end
            end else if (inject_rv) begin
                r_valid = 1'b1; r_data = 32'h0000_0077;
            end
            if (req) begin
                if (!stalling && !wen && wr_ord == stall_at && stall_len > 0) begin
                    stalling = 1; stall_left = stall_len; snap_add = add; snap_data = data;
                    stall_req_cyc = 0;
                end
                if (stalling) begin
                    stall_req_cyc++;
                    if (add !== snap_add || data !== snap_data) stall_unstable = 1;
                end
                if (stalling && stall_left > 0) stall_left--;
                else begin
                    gnt = 1'b1; stalling = 0;
                    log_add.push_back(add); log_data.push_back(data);
                    log_wen.push_back(wen); log_be.push_back(be);
                    if (wen && add == OFS_ACQUIRE) begin
                        acq_cyc.push_back(cyc); wr_ord = 0;
                        rsp_val = acq_tab[acq_ptr]; acq_ptr++;
                    end else begin
                        rsp_val = 32'h0;
                        if (!wen) wr_ord++;
                    end
                    rsp_trig = !wen && add == OFS_TRIGGER;
                    rsp_due = 1;
                end
            end else if (stalling) stall_unstable = 1;
        end
    end

    int done_cnt = 0;
    logic [7:0] done_id_at = '0;
    always @(negedge clk) if (done) begin done_cnt++; done_id_at = done_id; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int acq_wr = 0;

    task automatic submit(input logic [NP*32-1:0] p);
        @(posedge clk); #1;
        job_params = p; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    // Reference: (fails) failing reads, one good read, NP window writes, trigger
    task automatic run_job(input logic [NP*32-1:0] p, input int fails,
                           input logic [31:0] idw, input int edly, input string tag);
        int base, dc0, a0, k, n_exp;
        for (int f = 0; f < fails; f++) begin acq_tab[acq_wr] = ACQUIRE_FAIL; acq_wr++; end
        acq_tab[acq_wr] = idw; acq_wr++;
        evt_delay = edly;
        base = log_add.size(); dc0 = done_cnt; a0 = acq_cyc.size();
        n_exp = fails + 1 + NP + 1;
        submit(p);
        for (int c = 0; c < 3000 && done_cnt == dc0; c++) @(posedge clk);
        #1;
        chk({tag, "_done_seen"}, 32'(done_cnt != dc0), 1);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 32'(done_cnt - dc0), 1);
        chk({tag, "_done_id"}, 32'(done_id_at), 32'(idw[7:0]));
        chk({tag, "_id_hold"}, 32'(done_id), 32'(idw[7:0]));
        chk({tag, "_idle"}, 32'(busy), 0);
        chk({tag, "_ntrans"}, 32'(log_add.size() - base), 32'(n_exp));
        if (log_add.size() - base == n_exp) begin
            k = base;
            for (int f = 0; f <= fails; f++) begin
                chk({tag, "_acq_add"}, log_add[k], OFS_ACQUIRE);
                chk({tag, "_acq_wen"}, 32'(log_wen[k]), 1);
                k++;
            end
            for (int i = 0; i < NP; i++) begin
                chk({tag, "_wr_add"}, log_add[k], 32'h40 + 32'(4 * i));
                chk({tag, "_wr_data"}, log_data[k], p[i*32 +: 32]);
                chk({tag, "_wr_ctl"}, {27'h0, log_wen[k], log_be[k]}, 32'h0000_000F);
                k++;
            end
            chk({tag, "_trig_add"}, log_add[k], OFS_TRIGGER);
            chk({tag, "_trig_data"}, log_data[k], 0);
            chk({tag, "_trig_wen"}, 32'(log_wen[k]), 0);
        end
        for (int j = 0; j < fails; j++)
            if (acq_cyc.size() > a0 + j + 1)
                chk({tag, "_backoff_gap"}, 32'(acq_cyc[a0+j+1] - acq_cyc[a0+j] - 2), BO);
    endtask

    function automatic logic [31:0] rnd_id();
        logic [31:0] r;
        r = $urandom;
        if (r == ACQUIRE_FAIL) r = 32'h0;
        return r;
    endfunction

    initial begin
        logic [NP*32-1:0] p;
        int tr0, dc0, b0;

        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(job_ready), 1);
        chk("rst_req", 32'(req), 0);
        chk("rst_bus", {add[27:0], wen, be[2:0]}, 32'h0000_0008);
        chk("rst_data", data, 0);
        chk("rst_id", 32'(id), 0);
        chk("rst_done", {23'h0, done, done_id}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // nominal
        run_job({32'd4, 32'd3, 32'd2, 32'd1}, 0, 32'h0000_0003, 3, "nominal");

        // acquire busy twice then success
        for (int i = 0; i < NP; i++) p[i*32 +: 32] = $urandom;
        run_job(p, 2, 32'h0000_0001, 2, "acq_busy");

        // grant stall on third write
        stall_at = 2; stall_len = 5;
        for (int i = 0; i < NP; i++) p[i*32 +: 32] = $urandom;
        run_job(p, 0, rnd_id(), 4, "stall");
        chk("stall_req_cycles", 32'(stall_req_cyc), 6);
        chk("stall_stable", 32'(stall_unstable), 0);
        stall_at = -1;

        // event coincident with trigger response
        for (int i = 0; i < NP; i++) p[i*32 +: 32] = $urandom;
        run_job(p, 0, rnd_id(), 0, "evt_coinc");

        // response with foreign r_id must be ignored
        b0 = bad_rid_req; bad_rid_req = b0 + 1;
        for (int i = 0; i < NP; i++) p[i*32 +: 32] = $urandom;
        run_job(p, 0, rnd_id(), 1, "bad_rid");

        // clear while a write request is held off
        acq_tab[acq_wr] = 32'h0000_0005; acq_wr++;
        stall_at = 2; stall_len = 40; evt_delay = 5;
        for (int i = 0; i < NP; i++) p[i*32 +: 32] = $urandom;
        submit(p);
        for (int c = 0; c < 300 && !stalling; c++) @(posedge clk);
        @(posedge clk); #1;
        chk("clr_stall_req", 32'(req), 1);
        clear = 1'b1;
        #1 chk("clr_req_same", 32'(req), 0);
        @(posedge clk); #1;
        clear = 1'b0; stall_at = -1;
        chk("clr_req", 32'(req), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_ready", 32'(job_ready), 1);
        chk("clr_id", 32'(done_id), 0);
        inject_rv = 1'b1;
        @(posedge clk); #1 inject_rv = 1'b0;
        @(posedge clk); #1;
        chk("late_rv_busy", 32'(busy), 0);
        for (int i = 0; i < NP; i++) p[i*32 +: 32] = $urandom;
        run_job(p, 1, rnd_id(), 2, "after_clr");

        // async reset while waiting for the event
        acq_tab[acq_wr] = 32'h0000_009A; acq_wr++;
        evt_delay = 1000; tr0 = trig_rsp_cnt; dc0 = done_cnt;
        for (int i = 0; i < NP; i++) p[i*32 +: 32] = $urandom;
        submit(p);
        for (int c = 0; c < 300 && trig_rsp_cnt == tr0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_id", 32'(done_id), 32'h9A);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(job_ready), 1);
        chk("arst_req", 32'(req), 0);
        chk("arst_bus", {add[27:0], wen, be[2:0]}, 32'h0000_0008);
        chk("arst_done", {23'h0, done, done_id}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("arst_no_done", 32'(done_cnt - dc0), 0);

        // randomized jobs
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < NP; i++) p[i*32 +: 32] = $urandom;
            run_job(p, $urandom_range(0, 2), rnd_id(), $urandom_range(0, 6), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
